wb_master_seq: RTL and testbench
================================

# wb_master_seq

Single-transaction Wishbone classic initiator: the requesting end of the bus our wrapped projects respond on. It accepts one command at a time over a valid/ready port, runs one Wishbone read or write cycle, and waits for `ack` under a timeout. It returns read data or an error flag over a valid/ready response port. Projects use it to drive test registers or a shared peripheral from LA- or IO-driven command logic.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: number of BUS cycles without `ack` before the cycle is aborted. Legal range 1..65535.

Ports:
- Clock and reset: one clock, `wb_clk_i`; reset `wb_rst_i` is asynchronous and active-low.
- `wb_clk_i`  in  1: clock.
- `wb_rst_i`  in  1: reset, asynchronous, active-low.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_we`  in  1: 1 for write, 0 for read.
- `cmd_adr`  in  32: byte address.
- `cmd_dat`  in  32: write data.
- `cmd_sel`  in  4: byte selects.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_dat`  out  32: read data. 0 for writes and for timeouts.
- `rsp_err`  out  1: 1 when the cycle timed out.
- `wbm_cyc_o`, `wbm_stb_o`  out  1 each: bus cycle and strobe.
- `wbm_we_o`  out  1: write enable.
- `wbm_sel_o`  out  4: byte selects.
- `wbm_adr_o`  out  32: address.
- `wbm_dat_o`  out  32: write data.
- `wbm_dat_i`  in  32: read data.
- `wbm_ack_i`  in  1: responder acknowledge.
- `busy`  out  1: high in BUS or RESP.

## Operation
- Reset values: all outputs are 0 except `cmd_ready`, which is 1. State is IDLE and the timeout counter is 0.
- The FSM has three states: IDLE, BUS and RESP.
- IDLE:
  - `cmd_ready` = 1.
  - On accept, latch `we`, `adr`, `dat` and `sel` into the `wbm_*` registers, clear the counter, go to BUS.
- BUS:
  - `cyc` = `stb` = 1. `adr`, `we`, `sel` and `dat` are held stable.
  - `cmd_ready` = 0.
  - Counter increments every cycle without `ack`.
  - If `wbm_ack_i` = 1: capture `wbm_dat_i` into `rsp_dat` on reads (0 on writes), set `rsp_err` = 0, go to RESP.
  - Else, if the counter equals `TIMEOUT_CYCLES`-1: set `rsp_dat` = 0, `rsp_err` = 1, go to RESP.
  - If `ack` and the timeout condition coincide, `ack` wins.
- RESP:
  - `rsp_valid` = 1. `rsp_dat` and `rsp_err` are held stable until the handshake completes.
  - On `rsp_ready`, go to IDLE.
- `wbm_ack_i` outside BUS is ignored.
- `wbm_dat_o`/`wbm_we_o` keep their last values after a cycle ends. Only `cyc`/`stb` carry meaning.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`. It saturates and never wraps.
- Reset mid-operation: outputs drop to their reset values immediately (asynchronously). The transaction is abandoned with no response.

## Timing
- Command accepted at edge N: `cyc`/`stb` are high from N+1.
- `ack` sampled high at edge M: `cyc`/`stb` are low and `rsp_valid` is high from M+1. Zero-wait-state best case gives `rsp_valid` two cycles after accept.
- Timeout: `cyc`/`stb` stay high for exactly `TIMEOUT_CYCLES` cycles, then `rsp_valid` rises with `rsp_err` = 1.
- Response consumed at edge R: `cmd_ready` is high from R+1.
- Maximum throughput is one transaction per 3 cycles: accept, BUS, RESP.
- No combinational path from `wbm_ack_i` or `rsp_ready` to any output.

## Structure
- Package `wb_master_pkg`:
  - state enum (`ST_IDLE`, `ST_BUS`, `ST_RESP`),
  - default timeout constant,
  - `WB_AW`/`WB_DW`/`WB_SW` width constants (32/32/4).
- Single flat module. No sub-module.

## Test plan
- Write: cmd we=1, adr=0x3000_0004, dat=0xA5A5_0001, sel=0xF; responder acks on the 3rd BUS cycle. Expect `cyc`/`stb` high 3 cycles with the fields stable, then `rsp_valid`, `rsp_dat`=0, `rsp_err`=0.
- Read: cmd we=0, adr=0x3000_0000; responder returns 0x1234_5678 with zero wait. Expect `rsp_dat`=0x1234_5678 two cycles after accept.
- Timeout: `TIMEOUT_CYCLES`=8, no `ack`. Expect `cyc` high exactly 8 cycles, then `rsp_err`=1 and `rsp_dat`=0.
- Simultaneous: with `TIMEOUT_CYCLES`=8, `ack` arrives on the 8th BUS cycle with data 0xCAFE_F00D. Expect `rsp_err`=0 and `rsp_dat`=0xCAFE_F00D.
- Backpressure: hold `rsp_ready`=0 for 5 cycles. Expect `rsp_valid`/`rsp_dat` stable, `cmd_ready`=0 and `cyc`=0 throughout; `cmd_ready` returns 1 cycle after the handshake.
- Reset mid-BUS: assert `wb_rst_i` low with no clock edge. Expect `cyc`/`stb`/`rsp_valid`=0 immediately. After release, `cmd_ready`=1 and no stale response.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared types and constants for the single-transaction Wishbone classic initiator.
package wb_master_pkg;

    localparam int unsigned WB_AW           = 32;
    localparam int unsigned WB_DW           = 32;
    localparam int unsigned WB_SW           = 4;
    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;

endpackage : wb_master_pkg

// File: rtl/wb_master_seq.sv
// Wishbone classic initiator: one command in, one bus cycle with an ack timeout,
// one response out. Every output is a register, so ack/rsp_ready never reach an output combinationally.
module wb_master_seq
    import wb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [WB_AW-1:0] cmd_adr,
    input  logic [WB_DW-1:0] cmd_dat,
    input  logic [WB_SW-1:0] cmd_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WB_DW-1:0] rsp_dat,
    output logic             rsp_err,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [WB_SW-1:0] wbm_sel_o,
    output logic [WB_AW-1:0] wbm_adr_o,
    output logic [WB_DW-1:0] wbm_dat_o,
    input  logic [WB_DW-1:0] wbm_dat_i,
    input  logic             wbm_ack_i,
    output logic             busy
);

    localparam int unsigned    CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};

    wb_state_t        r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_cmd_ready;
    logic             r_rsp_valid;
    logic [WB_DW-1:0] r_rsp_dat;
    logic             r_rsp_err;
    logic             r_cyc;
    logic             r_stb;
    logic             r_we;
    logic [WB_SW-1:0] r_sel;
    logic [WB_AW-1:0] r_adr;
    logic [WB_DW-1:0] r_dat;
    logic             r_busy;

    // Transaction FSM; every output is updated alongside the state it belongs to.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_we        <= cmd_we;
                        r_adr       <= cmd_adr;
                        r_dat       <= cmd_dat;
                        r_sel       <= cmd_sel;
                        r_cnt       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_cyc       <= 1'b1;
                        r_stb       <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_BUS;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_BUS: begin
                    // ack is checked first so it wins over a coincident timeout
                    if (wbm_ack_i) begin
                        r_rsp_dat   <= r_we ? {WB_DW{1'b0}} : wbm_dat_i;
                        r_rsp_err   <= 1'b0;
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else begin
                            r_cnt <= r_cnt;
                        end
                        if (r_cnt == TO_LAST) begin
                            r_rsp_dat   <= '0;
                            r_rsp_err   <= 1'b1;
                            r_cyc       <= 1'b0;
                            r_stb       <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_state <= ST_BUS;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state <= ST_RESP;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_cyc       <= 1'b0;
                    r_stb       <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign busy      = r_busy;

endmodule : wb_master_seq

// File: tb/tb_wb_master_seq.sv
// Scoreboard bench for wb_master_seq with an 8-cycle timeout and a scripted Wishbone responder.
module tb_wb_master_seq;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_adr = 32'd0, cmd_dat = 32'd0;
    logic [3:0]  cmd_sel = 4'd0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = 32'd0;
    logic        wbm_ack_i = 1'b0;
    logic        busy;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } rsp_t;
    rsp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // Responder configuration and monitor state
    int          ack_on = 0;
    logic [31:0] rd_data = 32'd0;
    logic        stray_ack = 1'b0;
    int          bus_cnt = 0;
    int          field_err = 0;
    logic        exp_we;
    logic [31:0] exp_adr, exp_dat;
    logic [3:0]  exp_sel;

    wb_master_seq #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i (clk),       .wb_rst_i (rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr  (cmd_adr),   .cmd_dat  (cmd_dat),   .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Responder: counts bus cycles, checks held fields, drives ack/data for the next edge.
    always @(negedge clk) begin
        if (wbm_cyc_o) begin
            bus_cnt++;
            if (wbm_stb_o !== 1'b1 || busy !== 1'b1 || wbm_we_o !== exp_we ||
                wbm_adr_o !== exp_adr || wbm_dat_o !== exp_dat || wbm_sel_o !== exp_sel)
                field_err++;
            wbm_ack_i = (ack_on != 0) && (bus_cnt == ack_on);
            wbm_dat_i = wbm_ack_i ? rd_data : 32'hDEAD_BEEF;
        end else begin
            wbm_ack_i = stray_ack;
            wbm_dat_i = 32'hBAD0_BAD0;
        end
    end

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        @(negedge clk);
        exp_we = we; exp_adr = adr; exp_dat = dat; exp_sel = sel;
        bus_cnt = 0; field_err = 0;
        check_eq("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_we = ~we; cmd_adr = ~adr; cmd_dat = ~dat; cmd_sel = ~sel;
    endtask

    task automatic run_txn(input string tag, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel, input int ack,
                           input logic [31:0] rdata, input int hold);
        rsp_t exp_r;
        rsp_t got;
        int   exp_len;
        int   lat;
        int   bp_err;
        logic [31:0] held;
        ack_on  = ack;
        rd_data = rdata;
        exp_len = (ack != 0 && ack <= int'(TO)) ? ack : int'(TO);
        exp_r.err = !(ack != 0 && ack <= int'(TO));
        exp_r.dat = (exp_r.err || we) ? 32'd0 : rdata;
        sb_q.push_back(exp_r);
        issue(we, adr, dat, sel);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_len + 1));
        check_eq({tag, "_cyc_len"}, 64'(bus_cnt), 64'(exp_len));
        check_eq({tag, "_fields"}, 64'(field_err), 64'd0);
        if (hold > 0) begin
            bp_err = 0;
            held = rsp_dat;
            stray_ack = 1'b1;
            for (int i = 0; i < hold; i++) begin
                if (rsp_valid !== 1'b1 || rsp_dat !== held || cmd_ready !== 1'b0 ||
                    wbm_cyc_o !== 1'b0)
                    bp_err++;
                @(negedge clk);
            end
            stray_ack = 1'b0;
            check_eq({tag, "_backpressure"}, 64'(bp_err), 64'd0);
        end
        rsp_ready = 1'b1;
        if (sb_q.size() > 0) begin
            exp_r = sb_q.pop_front();
            got.dat = rsp_dat;
            got.err = rsp_err;
            check_eq({tag, "_rsp"}, 64'(got), 64'(exp_r));
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq({tag, "_post_hs"}, {62'd0, cmd_ready, rsp_valid}, 64'b10);
    endtask

    initial begin
        int stale;
        #12;
        check_eq("reset_ctrl", {cmd_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o,
                                wbm_we_o, busy}, 7'b1000000);
        check_eq("reset_rsp_dat", rsp_dat, 32'd0);
        check_eq("reset_bus", {wbm_sel_o, wbm_adr_o}, 36'd0);
        check_eq("reset_wdat", wbm_dat_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn("write",  1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF, 3, 32'h5555_AAAA, 0);
        run_txn("read",   1'b0, 32'h3000_0000, 32'h0000_0000, 4'hF, 1, 32'h1234_5678, 0);
        run_txn("tmo",    1'b0, 32'h3000_0010, 32'h0000_0000, 4'h3, 0, 32'h7777_7777, 0);
        run_txn("simul",  1'b0, 32'h3000_0020, 32'h0000_0000, 4'hF, 8, 32'hCAFE_F00D, 0);
        run_txn("bp",     1'b0, 32'h3000_0030, 32'h0000_0000, 4'h5, 2, 32'h0BAD_CAFE, 5);
        run_txn("wr_tmo", 1'b1, 32'h3000_0040, 32'hFFFF_0000, 4'h1, 0, 32'h1111_1111, 0);

        ack_on = 0;
        issue(1'b0, 32'h3000_0050, 32'd0, 4'hF);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_bus", {wbm_cyc_o, wbm_stb_o, rsp_valid, busy, cmd_ready}, 5'b00001);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        stale = 0;
        repeat (TO + 4) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready !== 1'b1) stale++;
        end
        rsp_ready = 1'b0;
        check_eq("rst_no_stale", 64'(stale), 64'd0);

        run_txn("rd_after_rst", 1'b0, 32'h3000_0060, 32'd0, 4'hF, 2, 32'h9ABC_DEF0, 0);
        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_wb_master_seq
